// File: rtl/gemm_mac_pe.sv
// gemm_mac_pe: systolic MAC processing element that accumulates signed operand products into a dot product,
// forwards each accepted operand pair east/south one cycle later, and holds the finished result under valid/ready.
module gemm_mac_pe #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         in_last,
    input  logic signed [DATA_WIDTH-1:0] a_in,
    input  logic signed [DATA_WIDTH-1:0] b_in,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] a_out,
    output logic signed [DATA_WIDTH-1:0] b_out,
    output logic                         fwd_valid,
    output logic                         fwd_last,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic signed [ACC_WIDTH-1:0]  res_data,
    output logic                         res_ovf
);
    typedef enum logic {ACCUM, HOLD} state_t;
    state_t state, state_next;
    logic signed [2*DATA_WIDTH-1:0] mul;
    logic signed [ACC_WIDTH-1:0] acc, prod, sum;
    logic ovf_acc, add_ovf, accept;
    assign mul     = (2*DATA_WIDTH)'(a_in) * (2*DATA_WIDTH)'(b_in);
    assign prod    = ACC_WIDTH'(mul);
    assign sum     = acc + prod;
    // two's-complement overflow: operands agree in sign but the wrapped sum does not
    assign add_ovf = (acc[ACC_WIDTH-1] == prod[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
    assign res_valid = (state == HOLD);
    always_comb begin
        in_ready   = rst && (state == ACCUM || res_ready);
        accept     = in_valid && in_ready;
        state_next = (accept && in_last) ? HOLD :
                     (state == HOLD && res_ready) ? ACCUM : state;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ACCUM;
            acc       <= '0;
            ovf_acc   <= 1'b0;
            res_data  <= '0;
            res_ovf   <= 1'b0;
            fwd_valid <= 1'b0;
            fwd_last  <= 1'b0;
            a_out     <= '0;
            b_out     <= '0;
        end else begin
            state     <= state_next;
            fwd_valid <= accept;
            if (accept) begin
                a_out    <= a_in;
                b_out    <= b_in;
                fwd_last <= in_last;
                acc      <= in_last ? '0 : sum;
                ovf_acc  <= in_last ? 1'b0 : (ovf_acc | add_ovf);
                if (in_last) begin
                    res_data <= sum;
                    res_ovf  <= ovf_acc | add_ovf;
                end
            end
        end
    end
endmodule

// File: tb/tb_gemm_mac_pe.sv
// tb_gemm_mac_pe: randomized scoreboard bench for gemm_mac_pe with an arithmetic reference model,
// plus a narrow-width instance exercising accumulator wrap and overflow.
module tb_gemm_mac_pe;
    localparam int DW = 16;
    localparam int AW = 40;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst, in_valid, in_last, in_ready, fwd_valid, fwd_last, res_valid, res_ready, res_ovf;
    logic signed [DW-1:0] a_in, b_in, a_out, b_out;
    logic signed [AW-1:0] res_data;
    logic rst8, in_valid8, in_last8, in_ready8, fwd_valid8, fwd_last8, res_valid8, res_ready8, res_ovf8;
    logic signed [7:0] a_in8, b_in8, a_out8, b_out8;
    logic signed [15:0] res_data8;

    gemm_mac_pe #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .a_in(a_in), .b_in(b_in),
        .in_ready(in_ready), .a_out(a_out), .b_out(b_out), .fwd_valid(fwd_valid), .fwd_last(fwd_last),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_ovf(res_ovf));
    gemm_mac_pe #(.DATA_WIDTH(8), .ACC_WIDTH(16)) dut8 (
        .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_last(in_last8), .a_in(a_in8), .b_in(b_in8),
        .in_ready(in_ready8), .a_out(a_out8), .b_out(b_out8), .fwd_valid(fwd_valid8), .fwd_last(fwd_last8),
        .res_valid(res_valid8), .res_ready(res_ready8), .res_data(res_data8), .res_ovf(res_ovf8));

    typedef struct {longint d; bit o;} res_t;
    typedef struct {int c; longint a; longint b; bit l;} fwd_t;
    res_t rq[$];
    fwd_t fq[$];
    int n_chk = 0, n_fail = 0, cyc = 0;
    longint m_acc = 0;
    bit m_ovf = 0, m_hold = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, longint act, longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic longint wrap(longint x);
        return (x <<< (64 - AW)) >>> (64 - AW);
    endfunction

    // monitor: retire results and forwarded beats against the scoreboard queues
    initial forever begin
        res_t r;
        fwd_t f;
        @(negedge clk);
        #1;
        if (rst) begin
            if (res_valid && res_ready) begin
                if (rq.size() == 0) chk("res_unexpected", 1, 0);
                else begin
                    r = rq.pop_front();
                    chk("res_data", res_data, r.d);
                    chk("res_ovf", res_ovf, r.o);
                end
            end
            if (res_valid && !res_ready) chk("hold_in_ready", in_ready, 0);
            if (fq.size() > 0 && fq[0].c == cyc - 1) begin
                f = fq.pop_front();
                chk("fwd_valid", fwd_valid, 1);
                chk("a_out", a_out, f.a);
                chk("b_out", b_out, f.b);
                chk("fwd_last", fwd_last, f.l);
            end else chk("fwd_idle", fwd_valid, 0);
        end
    end

    task automatic drive(bit v, longint a, longint b, bit l, bit rr);
        bit ok;
        longint ex, w;
        @(negedge clk);
        in_valid = v; a_in = DW'(a); b_in = DW'(b); in_last = l; res_ready = rr;
        #1;
        ok = v && rst && (!m_hold || rr);
        chk("in_ready", in_ready, rst && (!m_hold || rr));
        if (m_hold && rr) m_hold = 0;
        if (ok) begin
            ex = m_acc + a * b;
            w = wrap(ex);
            fq.push_back('{cyc, a, b, l});
            if (l) begin
                rq.push_back('{w, m_ovf || (ex != w)});
                m_acc = 0; m_ovf = 0; m_hold = 1;
            end else begin
                m_acc = w; m_ovf = m_ovf || (ex != w);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0; in_valid = 1; res_ready = 1;
        #1;
        chk("rst_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_ovf", res_ovf, 0);
        chk("rst_fwd_valid", fwd_valid, 0);
        chk("rst_fwd_last", fwd_last, 0);
        chk("rst_a_out", a_out, 0);
        chk("rst_b_out", b_out, 0);
        rq.delete(); fq.delete();
        m_acc = 0; m_ovf = 0; m_hold = 0;
        @(negedge clk);
        rst = 1; in_valid = 0;
    endtask

    initial begin
        longint a, b;
        rst = 0; in_valid = 0; in_last = 0; a_in = 0; b_in = 0; res_ready = 0;
        rst8 = 0; in_valid8 = 0; in_last8 = 0; a_in8 = 0; b_in8 = 0; res_ready8 = 0;
        repeat (2) @(posedge clk);
        do_reset();
        drive(1, 3, 4, 0, 1); drive(1, -2, 5, 0, 1); drive(1, 7, 1, 1, 1);
        drive(0, 0, 0, 0, 1); drive(0, 0, 0, 0, 1);
        drive(1, 2, 3, 1, 0);
        repeat (4) drive(1, 1, 1, 0, 0);
        drive(1, 1, 1, 0, 1); drive(1, 0, 0, 1, 1); drive(0, 0, 0, 0, 1);
        drive(1, 2, 3, 1, 1); drive(1, 5, 5, 1, 1);
        drive(0, 0, 0, 0, 1); drive(0, 0, 0, 0, 1);
        drive(1, 9, 9, 0, 1);
        do_reset();
        drive(1, 1, 2, 1, 1); drive(0, 0, 0, 0, 1);
        drive(1, -32768, -32768, 1, 1); drive(0, 0, 0, 0, 1);
        repeat (400) begin
            a = $urandom_range(0, 7) == 0 ? ($urandom_range(0, 1) ? -32768 : 32767) : longint'($signed(16'($urandom)));
            b = $urandom_range(0, 7) == 0 ? -32768 : longint'($signed(16'($urandom)));
            drive($urandom_range(0, 3) != 0, a, b, $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0);
        end
        repeat (4) drive(0, 0, 0, 0, 1);
        chk("res_queue_drained", rq.size(), 0);
        chk("fwd_queue_drained", fq.size(), 0);
        // narrow instance: three 127*127 beats wrap a 16-bit accumulator
        @(negedge clk);
        rst8 = 1; in_valid8 = 1; a_in8 = 127; b_in8 = 127; in_last8 = 0; res_ready8 = 1;
        @(negedge clk);
        @(negedge clk);
        in_last8 = 1;
        @(negedge clk);
        #1;
        chk("ovf8_res_valid", res_valid8, 1);
        chk("ovf8_res_data", res_data8, -17149);
        chk("ovf8_res_ovf", res_ovf8, 1);
        a_in8 = 1; b_in8 = 1;
        @(negedge clk);
        #1;
        chk("ovf8_next_valid", res_valid8, 1);
        chk("ovf8_next_data", res_data8, 1);
        chk("ovf8_next_ovf", res_ovf8, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
